// File: rtl/pipe_pkg.sv
// ---------------------------------------------------------------------------
// pipe_pkg -- shared definitions for the pipeline hazard/stall controller.
//   state_e         : controller FSM states (run, memory wait, halted)
//   REG_IDX_W       : width of architectural register numbers
//   MEM_TIMEOUT_DEF : default memory-wait budget in cycles
//   WAIT_CNT_W      : width of the memory-wait cycle counter
// ---------------------------------------------------------------------------
package pipe_pkg;

   typedef enum logic [1:0] {
      S_RUN  = 2'd0,
      S_WAIT = 2'd1,
      S_HALT = 2'd2
   } state_e;

   localparam int REG_IDX_W       = 4;
   localparam int MEM_TIMEOUT_DEF = 15;
   localparam int WAIT_CNT_W      = 8;

endpackage

// File: rtl/hazard_detect.sv
// ---------------------------------------------------------------------------
// hazard_detect -- combinational RAW hazard comparator for the ID stage.
// Ports:
//   id_src1/2, id_src1/2_vld : ID-stage source register numbers and use flags
//   exe_wb_en, exe_dest      : EXE-stage write-back enable and destination
//   exe_mem_read             : EXE-stage instruction is a load
//   mem_wb_en, mem_dest      : MEM-stage write-back enable and destination
//   hazard                   : ID must wait for a producer still in flight
// Build option:
//   PIPE_FWD_EN : forwarding present, so only load-use in EXE is a hazard.
// Register 0 is compared like any other register.
// ---------------------------------------------------------------------------
module hazard_detect
   import pipe_pkg::*;
(
   input  logic [REG_IDX_W-1:0] id_src1,
   input  logic [REG_IDX_W-1:0] id_src2,
   input  logic                 id_src1_vld,
   input  logic                 id_src2_vld,
   input  logic                 exe_wb_en,
   input  logic [REG_IDX_W-1:0] exe_dest,
   input  logic                 exe_mem_read,
   input  logic                 mem_wb_en,
   input  logic [REG_IDX_W-1:0] mem_dest,
   output logic                 hazard
);

   logic exe_qual_s;
   logic mem_qual_s;

`ifdef PIPE_FWD_EN
   // Forwarding covers ALU results and MEM-stage values; only a load in EXE
   // cannot be bypassed in time.
   logic unused_mem_s;
   assign exe_qual_s   = exe_wb_en & exe_mem_read;
   assign mem_qual_s   = 1'b0;
   assign unused_mem_s = ^{mem_wb_en, mem_dest};
`else
   // Without forwarding every in-flight writer blocks its readers, loads or not.
   logic unused_load_s;
   assign exe_qual_s    = exe_wb_en;
   assign mem_qual_s    = mem_wb_en;
   assign unused_load_s = exe_mem_read;
`endif

   logic src1_hit_s;
   logic src2_hit_s;

   assign src1_hit_s = id_src1_vld & ((exe_qual_s & (id_src1 == exe_dest)) |
                                      (mem_qual_s & (id_src1 == mem_dest)));
   assign src2_hit_s = id_src2_vld & ((exe_qual_s & (id_src2 == exe_dest)) |
                                      (mem_qual_s & (id_src2 == mem_dest)));
   assign hazard     = src1_hit_s | src2_hit_s;

endmodule

// File: rtl/pipeline_ctrl.sv
// ---------------------------------------------------------------------------
// pipeline_ctrl -- stall/flush controller for a 5-stage pipeline.
// Parameters:
//   MEM_TIMEOUT : consecutive memory-wait cycles tolerated before halting
//   CNT_W       : width of the saturating performance counters
// Ports:
//   clk, rst (synchronous, active-low)
//   id_src1/2(_vld), exe_wb_en/exe_dest/exe_mem_read, mem_wb_en/mem_dest
//                 : hazard comparator inputs
//   branch_taken, mem_req, mem_ready : control events
//   freeze, flush, id_bubble, pipe_stall, halted : pipeline controls
//   stall_cycles, flush_count : performance counters
// Build option:
//   PIPE_FWD_EN : selects the load-use-only hazard rule in hazard_detect.
// All control outputs are combinational from inputs and current state and
// are forced low while rst is asserted.
// ---------------------------------------------------------------------------
module pipeline_ctrl
   import pipe_pkg::*;
#(
   parameter int MEM_TIMEOUT = MEM_TIMEOUT_DEF,
   parameter int CNT_W       = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [REG_IDX_W-1:0] id_src1,
   input  logic [REG_IDX_W-1:0] id_src2,
   input  logic                 id_src1_vld,
   input  logic                 id_src2_vld,
   input  logic                 exe_wb_en,
   input  logic [REG_IDX_W-1:0] exe_dest,
   input  logic                 exe_mem_read,
   input  logic                 mem_wb_en,
   input  logic [REG_IDX_W-1:0] mem_dest,
   input  logic                 branch_taken,
   input  logic                 mem_req,
   input  logic                 mem_ready,
   output logic                 freeze,
   output logic                 flush,
   output logic                 id_bubble,
   output logic                 pipe_stall,
   output logic                 halted,
   output logic [CNT_W-1:0]     stall_cycles,
   output logic [CNT_W-1:0]     flush_count
);

   localparam logic [WAIT_CNT_W-1:0] TIMEOUT_C  = WAIT_CNT_W'(MEM_TIMEOUT);
   localparam logic [WAIT_CNT_W-1:0] WAIT_ONE_C = {{(WAIT_CNT_W-1){1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0]      CNT_ONE_C  = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0]      CNT_MAX_C  = {CNT_W{1'b1}};

   state_e                state_q, state_d;
   logic [WAIT_CNT_W-1:0] wait_cnt_q, wait_cnt_d;
   logic [CNT_W-1:0]      stall_cycles_q, stall_cycles_d;
   logic [CNT_W-1:0]      flush_count_q, flush_count_d;
   logic                  hazard_s;
   logic                  mem_busy_s;

   hazard_detect u_hazard_detect (
      .id_src1      (id_src1),
      .id_src2      (id_src2),
      .id_src1_vld  (id_src1_vld),
      .id_src2_vld  (id_src2_vld),
      .exe_wb_en    (exe_wb_en),
      .exe_dest     (exe_dest),
      .exe_mem_read (exe_mem_read),
      .mem_wb_en    (mem_wb_en),
      .mem_dest     (mem_dest),
      .hazard       (hazard_s)
   );

   assign mem_busy_s = mem_req & ~mem_ready;

   // State, wait counter and performance counter registers.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q        <= S_RUN;
         wait_cnt_q     <= {WAIT_CNT_W{1'b0}};
         stall_cycles_q <= {CNT_W{1'b0}};
         flush_count_q  <= {CNT_W{1'b0}};
      end else begin
         state_q        <= state_d;
         wait_cnt_q     <= wait_cnt_d;
         stall_cycles_q <= stall_cycles_d;
         flush_count_q  <= flush_count_d;
      end
   end

   // Next-state logic: memory wait tracking and timeout detection.
   always_comb begin
      state_d    = state_q;
      wait_cnt_d = wait_cnt_q;
      case (state_q)
         S_RUN: begin
            if (mem_busy_s) begin
               state_d    = S_WAIT;
               wait_cnt_d = {WAIT_CNT_W{1'b0}};
            end else begin
               state_d    = S_RUN;
            end
         end
         S_WAIT: begin
            // Completion is checked first so a ready in the timeout cycle wins.
            if (mem_ready || !mem_req) begin
               state_d = S_RUN;
            end else if ((wait_cnt_q + WAIT_ONE_C) == TIMEOUT_C) begin
               state_d    = S_HALT;
               wait_cnt_d = wait_cnt_q + WAIT_ONE_C;
            end else begin
               wait_cnt_d = wait_cnt_q + WAIT_ONE_C;
            end
         end
         S_HALT: begin
            state_d = S_HALT;
         end
         default: begin
            state_d    = S_RUN;
            wait_cnt_d = {WAIT_CNT_W{1'b0}};
         end
      endcase
   end

   // Output logic: priority is memory stall, then branch, then data hazard.
   always_comb begin
      freeze     = 1'b0;
      flush      = 1'b0;
      id_bubble  = 1'b0;
      pipe_stall = 1'b0;
      halted     = 1'b0;
      if (!rst) begin
         freeze     = 1'b0;
         pipe_stall = 1'b0;
      end else if (state_q == S_HALT) begin
         freeze     = 1'b1;
         pipe_stall = 1'b1;
         halted     = 1'b1;
      end else begin
         pipe_stall = mem_busy_s;
         flush      = branch_taken & ~mem_busy_s;
         // A taken branch discards the hazarding instruction, so the PC is
         // left free to load the branch target.
         freeze     = mem_busy_s | (hazard_s & ~branch_taken);
         id_bubble  = hazard_s & ~branch_taken & ~mem_busy_s;
      end
   end

   // Saturating performance counters.
   always_comb begin
      if (freeze && (stall_cycles_q != CNT_MAX_C)) begin
         stall_cycles_d = stall_cycles_q + CNT_ONE_C;
      end else begin
         stall_cycles_d = stall_cycles_q;
      end
      if (flush && (flush_count_q != CNT_MAX_C)) begin
         flush_count_d = flush_count_q + CNT_ONE_C;
      end else begin
         flush_count_d = flush_count_q;
      end
   end

   assign stall_cycles = stall_cycles_q;
   assign flush_count  = flush_count_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pipeline_ctrl -- directed self-checking bench for pipeline_ctrl.
// DUT built with MEM_TIMEOUT=4 and CNT_W=4. Expected outputs come from a
// small behavioural model, queued when inputs are applied and compared on
// the falling edge; key scenarios also carry constant expectations.
// Honours PIPE_FWD_EN for the hazard rule.
// ---------------------------------------------------------------------------
module tb_pipeline_ctrl;

   localparam int TO = 4;
   localparam int CW = 4;
   localparam int CMAX = (1 << CW) - 1;
`ifdef PIPE_FWD_EN
   localparam logic [3:0] RAW_ALU_FREEZE = 4'd0;
`else
   localparam logic [3:0] RAW_ALU_FREEZE = 4'd1;
`endif

   logic          clk = 1'b0;
   logic          rst;
   logic [3:0]    id_src1, id_src2, exe_dest, mem_dest;
   logic          id_src1_vld, id_src2_vld, exe_wb_en, exe_mem_read, mem_wb_en;
   logic          branch_taken, mem_req, mem_ready;
   logic          freeze, flush, id_bubble, pipe_stall, halted;
   logic [CW-1:0] stall_cycles, flush_count;

   typedef struct packed {
      logic       frz;
      logic       fl;
      logic       bub;
      logic       stl;
      logic       hlt;
      logic [3:0] sc;
      logic [3:0] fc;
   } exp_t;

   exp_t sb[$];
   int   vectors = 0;
   int   miscompares = 0;
   int   m_state = 0;
   int   m_cnt = 0;
   int   m_sc = 0;
   int   m_fc = 0;
   bit   m_known = 1'b0;

   always #5 clk = ~clk;

   pipeline_ctrl #(.MEM_TIMEOUT(TO), .CNT_W(CW)) dut (
      .clk(clk), .rst(rst),
      .id_src1(id_src1), .id_src2(id_src2),
      .id_src1_vld(id_src1_vld), .id_src2_vld(id_src2_vld),
      .exe_wb_en(exe_wb_en), .exe_dest(exe_dest), .exe_mem_read(exe_mem_read),
      .mem_wb_en(mem_wb_en), .mem_dest(mem_dest),
      .branch_taken(branch_taken), .mem_req(mem_req), .mem_ready(mem_ready),
      .freeze(freeze), .flush(flush), .id_bubble(id_bubble),
      .pipe_stall(pipe_stall), .halted(halted),
      .stall_cycles(stall_cycles), .flush_count(flush_count)
   );

   task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic src_hit(input logic vld, input logic [3:0] src);
`ifdef PIPE_FWD_EN
      return vld && exe_wb_en && exe_mem_read && (src == exe_dest);
`else
      return vld && ((exe_wb_en && (src == exe_dest)) || (mem_wb_en && (src == mem_dest)));
`endif
   endfunction

   function automatic exp_t model_out();
      exp_t e;
      logic hz, st;
      e    = '0;
      e.sc = 4'(m_sc);
      e.fc = 4'(m_fc);
      hz   = src_hit(id_src1_vld, id_src1) | src_hit(id_src2_vld, id_src2);
      if (rst) begin
         if (m_state == 2) begin
            e.frz = 1'b1; e.stl = 1'b1; e.hlt = 1'b1;
         end else begin
            st    = mem_req & ~mem_ready;
            e.stl = st;
            e.fl  = branch_taken & ~st;
            e.frz = st | (hz & ~branch_taken);
            e.bub = hz & ~branch_taken & ~st;
         end
      end
      return e;
   endfunction

   task automatic model_step(input exp_t e);
      if (!rst) begin
         m_state = 0; m_cnt = 0; m_sc = 0; m_fc = 0; m_known = 1'b1;
      end else begin
         if (e.frz && m_sc < CMAX) m_sc++;
         if (e.fl && m_fc < CMAX) m_fc++;
         case (m_state)
            0: if (mem_req && !mem_ready) begin m_state = 1; m_cnt = 0; end
            1: begin
               if (mem_ready || !mem_req) m_state = 0;
               else if (m_cnt + 1 == TO) m_state = 2;
               else m_cnt++;
            end
            default: m_state = 2;
         endcase
      end
   endtask

   // One clock: queue expectation, compare on falling edge, advance model.
   task automatic cyc(input int n = 1);
      exp_t g;
      for (int i = 0; i < n; i++) begin
         sb.push_back(model_out());
         @(negedge clk);
         g = sb.pop_front();
         chk("freeze", freeze, g.frz);
         chk("flush", flush, g.fl);
         chk("id_bubble", id_bubble, g.bub);
         chk("pipe_stall", pipe_stall, g.stl);
         chk("halted", halted, g.hlt);
         if (m_known) begin
            chk("stall_cycles", stall_cycles, g.sc);
            chk("flush_count", flush_count, g.fc);
         end
         @(posedge clk);
         model_step(g);
         #1;
      end
   endtask

   task automatic idle();
      rst = 1'b1;
      id_src1 = 4'd0; id_src2 = 4'd0; exe_dest = 4'd0; mem_dest = 4'd0;
      id_src1_vld = 1'b0; id_src2_vld = 1'b0; exe_wb_en = 1'b0;
      exe_mem_read = 1'b0; mem_wb_en = 1'b0;
      branch_taken = 1'b0; mem_req = 1'b0; mem_ready = 1'b0;
   endtask

   task automatic do_reset();
      idle();
      rst = 1'b0;
      cyc(1);
      rst = 1'b1;
   endtask

   initial begin
      #50000;
      $display("FAIL watchdog expired observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset held two cycles with a pending memory request.
      idle();
      rst = 1'b0; mem_req = 1'b1;
      #1;
      chk("rst_freeze", freeze, 4'd0);
      chk("rst_pipe_stall", pipe_stall, 4'd0);
      cyc(2);
      chk("rst_stall_cycles", stall_cycles, 4'd0);
      idle();
      cyc(2);

      // RAW on EXE ALU result, then load-use.
      id_src1 = 4'd3; id_src1_vld = 1'b1; exe_dest = 4'd3; exe_wb_en = 1'b1;
      #1;
      chk("raw_alu_freeze", freeze, RAW_ALU_FREEZE);
      chk("raw_alu_bubble", id_bubble, RAW_ALU_FREEZE);
      cyc(1);
      exe_mem_read = 1'b1;
      #1;
      chk("load_use_freeze", freeze, 4'd1);
      cyc(1);

      // MEM-stage match on src2, register 0 match, invalid source.
      idle(); id_src2 = 4'd5; id_src2_vld = 1'b1; mem_dest = 4'd5; mem_wb_en = 1'b1;
      cyc(1);
      idle(); id_src1 = 4'd0; id_src1_vld = 1'b1; exe_wb_en = 1'b1; exe_mem_read = 1'b1;
      cyc(1);
      id_src1_vld = 1'b0;
      cyc(1);

      // Branch beats hazard.
      do_reset();
      id_src1 = 4'd9; id_src1_vld = 1'b1; exe_dest = 4'd9; exe_wb_en = 1'b1;
      exe_mem_read = 1'b1; branch_taken = 1'b1;
      #1;
      chk("br_flush", flush, 4'd1);
      chk("br_freeze", freeze, 4'd0);
      cyc(1);
      chk("br_flush_count", flush_count, 4'd1);
      // Memory stall beats branch.
      mem_req = 1'b1;
      cyc(1);
      mem_ready = 1'b1;
      cyc(1);

      // Memory wait: three busy cycles then ready.
      do_reset();
      mem_req = 1'b1;
      cyc(3);
      mem_ready = 1'b1;
      #1;
      chk("wait_ready_stall", pipe_stall, 4'd0);
      cyc(1);
      chk("wait_stall_cycles", stall_cycles, 4'd3);
      // Ready arriving in the timeout cycle returns to run.
      mem_ready = 1'b0;
      cyc(4);
      mem_ready = 1'b1;
      cyc(1);
      mem_ready = 1'b0; mem_req = 1'b0;
      cyc(1);
      chk("ready_wins_halted", halted, 4'd0);
      // Request withdrawn while waiting.
      mem_req = 1'b1;
      cyc(2);
      mem_req = 1'b0;
      cyc(2);

      // Timeout to halt, sticky until reset.
      do_reset();
      mem_req = 1'b1;
      cyc(5);
      chk("timeout_halted", halted, 4'd1);
      mem_req = 1'b0; branch_taken = 1'b1;
      cyc(3);
      chk("halt_sticky", halted, 4'd1);
      chk("halt_freeze", freeze, 4'd1);
      rst = 1'b0;
      cyc(1);
      rst = 1'b1; branch_taken = 1'b0;
      cyc(1);
      chk("halt_reset_exit", halted, 4'd0);

      // Counter saturation.
      do_reset();
      id_src1 = 4'd7; id_src1_vld = 1'b1; exe_dest = 4'd7; exe_wb_en = 1'b1; exe_mem_read = 1'b1;
      cyc(20);
      chk("stall_sat", stall_cycles, 4'd15);
      idle(); branch_taken = 1'b1;
      cyc(20);
      chk("flush_sat", flush_count, 4'd15);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/pipeline_ctrl.md
PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

Interface
REQ-001 SHALL have parameter MEM_TIMEOUT, default 15, max consecutive memory-wait cycles before error (range 1..255).
REQ-002 SHALL have parameter CNT_W, default 16, width of the performance counters.
REQ-003 SHALL have port clk  in  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  in  1  reset, synchronous, active-low.
REQ-005 SHALL have ports id_src1, id_src2  in  4 each  ID-stage source register numbers; id_src1_vld, id_src2_vld  in  1 each  source is used.
REQ-006 SHALL have ports exe_wb_en  in  1, exe_dest  in  4, exe_mem_read  in  1  EXE-stage write-back info.
REQ-007 SHALL have ports mem_wb_en  in  1, mem_dest  in  4  MEM-stage write-back info.
REQ-008 SHALL have ports branch_taken  in  1  EXE branch resolved taken; mem_req  in  1  MEM stage accessing data memory; mem_ready  in  1  memory access completes this cycle.
REQ-009 SHALL have outputs freeze  1  hold PC and IF/ID register; flush  1  clear IF/ID register; id_bubble  1  load NOP into ID/EXE register; pipe_stall  1  hold every pipeline register; halted  1  sticky memory-timeout error.
REQ-010 SHALL have outputs stall_cycles  CNT_W  and flush_count  CNT_W  performance counters.

Function
REQ-011 hazard SHALL be 1 when a valid ID source equals exe_dest with exe_wb_en=1, or equals mem_dest with mem_wb_en=1 (forwarding-disabled form; see REQ-025).
REQ-012 pipe_stall SHALL equal mem_req & ~mem_ready in S_RUN/S_WAIT, and 1 in S_HALT.
REQ-013 Priority SHALL be pipe_stall > branch_taken > hazard.
REQ-014 flush SHALL equal branch_taken & ~pipe_stall; freeze SHALL be 0 while flush=1 so the branch target loads.
REQ-015 freeze SHALL equal pipe_stall | (hazard & ~branch_taken); id_bubble SHALL equal hazard & ~branch_taken & ~pipe_stall.
REQ-016 FSM states SHALL be S_RUN, S_WAIT, S_HALT; S_RUN->S_WAIT when mem_req & ~mem_ready; S_WAIT->S_RUN when mem_ready=1 or mem_req=0; S_WAIT->S_HALT when wait_cnt reaches MEM_TIMEOUT; S_HALT exits only by reset.
REQ-017 wait_cnt (8-bit) SHALL clear on entry to S_WAIT and increment each S_WAIT cycle with mem_ready=0; a ready arriving in the timeout cycle SHALL win (return to S_RUN).
REQ-018 halted SHALL be 1 exactly in S_HALT; in S_HALT flush=0, id_bubble=0, freeze=1.
REQ-019 stall_cycles SHALL increment each cycle freeze=1, saturating at all-ones; flush_count SHALL increment each cycle flush=1, saturating.
REQ-020 Register 0 SHALL NOT be special-cased: matches on register 0 cause hazards like any other.
REQ-021 All outputs SHALL be combinational from current inputs and state, zero added latency.

Reset
REQ-022 While rst=0 at a clock edge: state<=S_RUN, wait_cnt<=0, stall_cycles<=0, flush_count<=0.
REQ-023 During the reset cycle freeze, flush, id_bubble, pipe_stall, halted SHALL all be driven 0.
REQ-024 Reset mid-S_WAIT or in S_HALT SHALL return to S_RUN on the next edge, counters cleared.

Configuration
REQ-025 With macro PIPE_FWD_EN defined, hazard SHALL be 1 only for a valid ID source matching exe_dest with exe_wb_en=1 and exe_mem_read=1 (load-use); MEM-stage matches SHALL be ignored. Without it, REQ-011 applies.

Structure
REQ-026 Package pipe_pkg SHALL hold the state enum (S_RUN, S_WAIT, S_HALT), REG_IDX_W=4 and the default MEM_TIMEOUT.
REQ-027 The combinational comparator SHALL be a sub-module hazard_detect (sources, dest info in; hazard out); FSM and counters stay in pipeline_ctrl.

Verification
REQ-028 Reset: rst=0 for 2 cycles with mem_req=1 -> all outputs 0, counters 0.
REQ-029 RAW: id_src1=3, vld=1, exe_dest=3, exe_wb_en=1, exe_mem_read=0 -> no FWD: freeze=1, id_bubble=1; PIPE_FWD_EN: freeze=0; with exe_mem_read=1 both builds freeze=1.
REQ-030 Branch vs hazard: branch_taken=1 with hazard active -> flush=1, freeze=0, id_bubble=0, flush_count +1.
REQ-031 Memory wait: mem_req=1, mem_ready low 3 cycles then high -> pipe_stall=1 for 3 cycles, 0 on the ready cycle, state back to S_RUN, stall_cycles=3.
REQ-032 Timeout: mem_req=1, mem_ready=0 held, MEM_TIMEOUT=4 -> S_HALT after 5 cycles, halted=1 sticky, freeze=1 until rst=0.
REQ-033 Saturation: CNT_W=4, freeze held 20 cycles -> stall_cycles stops at 15.
